// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: source ids, buffered entry type and round-robin helper for the CDB arbiter
`include "const_def.v"
package cdb_arbiter_pkg;
  localparam int NUM_SRC = 3;
  typedef enum logic [1:0] {
    SRC_ALU0 = 2'd0,
    SRC_ALU1 = 2'd1,
    SRC_MEM  = 2'd2
  } src_e;
  typedef struct packed {
    logic [`ROB_RANGE] rob_id;
    logic [31:0]       value;
  } cdb_entry_t;
  function automatic src_e next_src(input src_e s);
    return s == SRC_MEM ? SRC_ALU0 : src_e'(s + 2'd1);
  endfunction
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: per-source result buffer feeding the CDB arbiter
//   clk_in/rst_in/flush_in : clock, sync reset, pipeline flush (both clear the buffer)
//   i_valid/i_entry        : offered result; tag 0 is dropped
//   o_ready                : room for one entry, forced low during reset/flush
//   i_pop/o_empty/o_head   : arbiter pop strobe, empty flag, head entry
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       flush_in,
  input  logic       i_valid,
  input  cdb_entry_t i_entry,
  input  logic       i_pop,
  output logic       o_ready,
  output logic       o_empty,
  output cdb_entry_t o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  cdb_entry_t    r_mem [DEPTH];
  logic          w_push, w_pop;
  // ready depends only on the registered count, never on a same-cycle pop
  assign o_ready = !rst_in && !flush_in && (r_cnt < CW'(DEPTH));
  assign o_empty = r_cnt == '0;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_valid && o_ready && i_entry.rob_id != `ROB_INVALID;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (flush_in) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_entry;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/const_def.v
// const_def: shared ROB tag width, tag range and the invalid-tag constant
`ifndef CONST_DEF_V
`define CONST_DEF_V
`define ROB_WIDTH 6
`define ROB_RANGE 5:0
`define ROB_INVALID 6'd0
`endif

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of ALU0/ALU1/MEM results onto the common data bus
//   clk_in, rst_in (sync, active-high), flush_in (from ROB)
//   <src>_valid/_rob_id/_value : result offers; <src>_ready : buffer has room
//   cdb_rob_id/cdb_value       : registered broadcast, tag 0 means idle
`include "const_def.v"
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              alu0_valid,
  input  logic              alu1_valid,
  input  logic              mem_valid,
  input  logic [`ROB_RANGE] alu0_rob_id,
  input  logic [`ROB_RANGE] alu1_rob_id,
  input  logic [`ROB_RANGE] mem_rob_id,
  input  logic [31:0]       alu0_value,
  input  logic [31:0]       alu1_value,
  input  logic [31:0]       mem_value,
  output logic              alu0_ready,
  output logic              alu1_ready,
  output logic              mem_ready,
  output logic [`ROB_RANGE] cdb_rob_id,
  output logic [31:0]       cdb_value
);
  logic       [NUM_SRC-1:0] w_valid, w_ready, w_empty, w_pop;
  cdb_entry_t               w_in   [NUM_SRC];
  cdb_entry_t               w_head [NUM_SRC];
  src_e                     r_rr, w_c1, w_c2, w_c3, w_gnt;
  logic                     w_gnt_vld;
  assign w_valid = {mem_valid, alu1_valid, alu0_valid};
  assign w_in[SRC_ALU0] = '{rob_id: alu0_rob_id, value: alu0_value};
  assign w_in[SRC_ALU1] = '{rob_id: alu1_rob_id, value: alu1_value};
  assign w_in[SRC_MEM]  = '{rob_id: mem_rob_id, value: mem_value};
  assign {mem_ready, alu1_ready, alu0_ready} = w_ready;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .flush_in(flush_in),
      .i_valid (w_valid[g]),
      .i_entry (w_in[g]),
      .i_pop   (w_pop[g]),
      .o_ready (w_ready[g]),
      .o_empty (w_empty[g]),
      .o_head  (w_head[g])
    );
  end
  // candidates in priority order starting at the round-robin pointer
  always_comb begin
    w_c1      = r_rr;
    w_c2      = next_src(w_c1);
    w_c3      = next_src(w_c2);
    w_gnt_vld = !(&w_empty);
    w_gnt     = !w_empty[w_c1] ? w_c1 : !w_empty[w_c2] ? w_c2 : w_c3;
    w_pop     = w_gnt_vld ? NUM_SRC'(1) << w_gnt : '0;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rr       <= SRC_ALU0;
      cdb_rob_id <= `ROB_INVALID;
      cdb_value  <= '0;
    end else if (flush_in) begin
      r_rr       <= SRC_ALU0;
      cdb_rob_id <= `ROB_INVALID;
    end else if (w_gnt_vld) begin
      r_rr       <= next_src(w_gnt);
      cdb_rob_id <= w_head[w_gnt].rob_id;
      cdb_value  <= w_head[w_gnt].value;
    end else begin
      cdb_rob_id <= `ROB_INVALID;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed table plus hand sequences for the CDB arbiter
module tb_cdb_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, flush_in;
  logic        alu0_valid, alu1_valid, mem_valid;
  logic [5:0]  alu0_rob_id, alu1_rob_id, mem_rob_id;
  logic [31:0] alu0_value, alu1_value, mem_value;
  logic        alu0_ready, alu1_ready, mem_ready;
  logic [5:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  int tests = 0;
  int bad = 0;
  always #5 clk_in = ~clk_in;
  cdb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .alu0_valid(alu0_valid), .alu1_valid(alu1_valid), .mem_valid(mem_valid),
    .alu0_rob_id(alu0_rob_id), .alu1_rob_id(alu1_rob_id), .mem_rob_id(mem_rob_id),
    .alu0_value(alu0_value), .alu1_value(alu1_value), .mem_value(mem_value),
    .alu0_ready(alu0_ready), .alu1_ready(alu1_ready), .mem_ready(mem_ready),
    .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value)
  );
  typedef struct {
    string       nm;
    logic        r, f;
    logic [2:0]  v;
    logic [5:0]  i0, i1, im;
    logic [31:0] x0, x1, xm;
    logic [2:0]  rdy;
    logic [5:0]  eid;
    logic [31:0] ev;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(string nm, logic r, logic f, logic [2:0] v,
                              logic [5:0] i0, logic [31:0] x0, logic [5:0] i1, logic [31:0] x1,
                              logic [5:0] im, logic [31:0] xm, logic [2:0] rdy,
                              logic [5:0] eid, logic [31:0] ev);
    vec_t t;
    t.nm = nm; t.r = r; t.f = f; t.v = v;
    t.i0 = i0; t.x0 = x0; t.i1 = i1; t.x1 = x1; t.im = im; t.xm = xm;
    t.rdy = rdy; t.eid = eid; t.ev = ev;
    return t;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(logic r, logic f, logic [2:0] v, logic [5:0] i0, logic [31:0] x0,
                       logic [5:0] i1, logic [31:0] x1, logic [5:0] im, logic [31:0] xm);
    rst_in = r; flush_in = f;
    {mem_valid, alu1_valid, alu0_valid} = v;
    alu0_rob_id = i0; alu0_value = x0;
    alu1_rob_id = i1; alu1_value = x1;
    mem_rob_id = im; mem_value = xm;
  endtask
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic do_reset;
    drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask
  logic [5:0] bp_exp [10];
  logic       mr_exp [5];
  logic [5:0] mt [3];
  initial begin
    tbl.push_back(mk("rst",      1, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b000,  0, 0));
    tbl.push_back(mk("single0",  0, 0, 3'b001,  5, 'h1234, 0, 0,     0, 0,     3'b111,  0, 0));
    tbl.push_back(mk("single1",  0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  5, 'h1234));
    tbl.push_back(mk("single2",  0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  0, 'h1234));
    tbl.push_back(mk("rst2",     1, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b000,  0, 0));
    tbl.push_back(mk("simul0",   0, 0, 3'b111,  3, 'hA,    4, 'hB,   7, 'hC,   3'b111,  0, 0));
    tbl.push_back(mk("simul1",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  3, 'hA));
    tbl.push_back(mk("simul2",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  4, 'hB));
    tbl.push_back(mk("simul3",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  7, 'hC));
    tbl.push_back(mk("simul4",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  0, 'hC));
    tbl.push_back(mk("inval0",   0, 0, 3'b010,  0, 0,      0, 'hFF,  0, 0,     3'b111,  0, 'hC));
    tbl.push_back(mk("inval1",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  0, 'hC));
    tbl.push_back(mk("inval2",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  0, 'hC));
    tbl.push_back(mk("flushA",   0, 0, 3'b101, 21, 'h21,   0, 0,    22, 'h22,  3'b111,  0, 'hC));
    tbl.push_back(mk("flushB",   0, 0, 3'b101, 24, 'h24,   0, 0,    23, 'h23,  3'b111, 21, 'h21));
    tbl.push_back(mk("flushC",   0, 1, 3'b010,  0, 0,      6, 'h6,   0, 0,     3'b000,  0, 'h21));
    tbl.push_back(mk("flushD",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  0, 'h21));
    tbl.push_back(mk("flushE",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  0, 'h21));
    tbl.push_back(mk("flushF",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  0, 'h21));
    tbl.push_back(mk("rrrst0",   0, 0, 3'b111,  1, 'h101,  2, 'h102, 3, 'h103, 3'b111,  0, 'h21));
    tbl.push_back(mk("rrrst1",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  1, 'h101));
    tbl.push_back(mk("rrrst2",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  2, 'h102));
    tbl.push_back(mk("rrrst3",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  3, 'h103));
    tbl.push_back(mk("rrrst4",   0, 0, 3'b000,  0, 0,      0, 0,     0, 0,     3'b111,  0, 'h103));
    drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    #2;
    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].f, tbl[n].v, tbl[n].i0, tbl[n].x0, tbl[n].i1, tbl[n].x1,
            tbl[n].im, tbl[n].xm);
      #1;
      chk({tbl[n].nm, ".ready"}, {29'd0, mem_ready, alu1_ready, alu0_ready}, {29'd0, tbl[n].rdy});
      tick();
      chk({tbl[n].nm, ".rob_id"}, {26'd0, cdb_rob_id}, {26'd0, tbl[n].eid});
      chk({tbl[n].nm, ".value"}, cdb_value, tbl[n].ev);
    end
    // backpressure: alu0/alu1 stream continuously, mem offers 9,10,11 back to back
    bp_exp = '{0, 32, 48, 9, 33, 49, 10, 34, 50, 11};
    mr_exp = '{1, 1, 0, 0, 1};
    mt = '{9, 10, 11};
    do_reset();
    begin
      logic [5:0] t0, t1;
      int mi;
      logic a0, a1, am;
      t0 = 32; t1 = 48; mi = 0;
      for (int c = 0; c < 10; c++) begin
        drive(0, 0, {mi < 3, 2'b11}, t0, {26'd0, t0}, t1, {26'd0, t1},
              mi < 3 ? mt[mi] : 6'd0, 32'h900 + mi);
        #1;
        if (c < 5) chk($sformatf("bp.mem_ready%0d", c), {31'd0, mem_ready}, {31'd0, mr_exp[c]});
        a0 = alu0_ready; a1 = alu1_ready; am = mem_ready && mi < 3;
        tick();
        if (a0) t0++;
        if (a1) t1++;
        if (am) mi++;
        chk($sformatf("bp.rob_id%0d", c), {26'd0, cdb_rob_id}, {26'd0, bp_exp[c]});
      end
      chk("bp.mem_accepted", mi, 3);
    end
    // wrap-around through alu0 alone
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      if (k <= 10) drive(0, 0, 3'b001, 6'(k), k * 3, 0, 0, 0, 0);
      else drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("wrap.ready%0d", k), {31'd0, alu0_ready}, 1);
      tick();
      chk($sformatf("wrap.rob_id%0d", k), {26'd0, cdb_rob_id}, k - 1);
      if (k > 1) chk($sformatf("wrap.value%0d", k), cdb_value, (k - 1) * 3);
    end
    // reset in the middle of traffic discards everything buffered
    drive(0, 0, 3'b111, 40, 'h40, 41, 'h41, 42, 'h42);
    tick();
    drive(1, 0, 3'b001, 43, 'h43, 0, 0, 0, 0);
    #1;
    chk("mrst.ready_in_rst", {29'd0, mem_ready, alu1_ready, alu0_ready}, 0);
    tick();
    chk("mrst.rob_id", {26'd0, cdb_rob_id}, 0);
    chk("mrst.value", cdb_value, 0);
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("mrst.ready%0d", k), {29'd0, mem_ready, alu1_ready, alu0_ready}, 7);
      tick();
      chk($sformatf("mrst.idle%0d", k), {26'd0, cdb_rob_id}, 0);
    end
    $display("test done: total=%0d bad=%0d", tests, bad);
    $finish;
  end
endmodule
